pipe_stage_skid: RTL and testbench

- Parametrised pipeline boundary register for the CPU back end; the next generation of the fixed-width stage registers between EX and the memory stages.
- Carries a payload bus plus a side request bus (e.g. data SRAM request) through a 2-entry skid buffer.
- Uses a valid/ready handshake layered on the global stall vector and flush.
- Request outputs are held stable under stall and are zeroed whenever no valid entry is present, so a bubble never issues a memory request.

---
 rtl/pipe_stage_skid.sv | 116 +++++++++++
 tb/tb_pipe_stage_skid.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with a 2-entry skid buffer (main/head + skid) carrying payload and side request.
// Latency: 1 cycle from accept to out_valid; all outputs come straight from registers (no in_* -> out_* path).
// Backpressure: in_ready drops only when the skid holds an entry; stall[STAGE] blocks accepts, stall[STAGE+1] freezes the head.
module pipe_stage_skid #(
  parameter int DATA_WD     = 64,
  parameter int REQ_WD      = 69,
  parameter int STALL_WD    = 6,
  parameter int STAGE       = 4,   // STAGE+1 must be a valid index into stall
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic [STALL_WD-1:0] stall,
  input  logic                in_valid,
  input  logic [DATA_WD-1:0]  in_bus,
  input  logic [REQ_WD-1:0]   in_req,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DATA_WD-1:0]  out_bus,
  output logic [REQ_WD-1:0]   out_req,
  input  logic                out_ready,
  output logic [1:0]          occ
);

  logic               main_vld_q, main_vld_d;
  logic [DATA_WD-1:0] main_bus_q, main_bus_d;
  logic [REQ_WD-1:0]  main_req_q, main_req_d;
  logic               skid_vld_q, skid_vld_d;
  logic [DATA_WD-1:0] skid_bus_q, skid_bus_d;
  logic [REQ_WD-1:0]  skid_req_q, skid_req_d;

  logic accept;
  logic pop;

  // Only two bits of the stall vector matter to this stage; the rest are folded here.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Ready depends on state only, so upstream never sees a combinational loop through this stage.
  assign in_ready = !skid_vld_q;
  assign accept   = in_valid && in_ready && !stall[STAGE];
  assign pop      = main_vld_q && out_ready && !stall[STAGE+1];

  assign out_valid = main_vld_q;
  assign out_bus   = (ZERO_BUBBLE && !main_vld_q) ? '0 : main_bus_q;
  assign out_req   = (ZERO_BUBBLE && !main_vld_q) ? '0 : main_req_q;
  assign occ       = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

  // Next-state: flush wipes everything; otherwise pop/accept decide where entries move.
  always_comb begin
    main_vld_d = main_vld_q;
    main_bus_d = main_bus_q;
    main_req_d = main_req_q;
    skid_vld_d = skid_vld_q;
    skid_bus_d = skid_bus_q;
    skid_req_d = skid_req_q;
    if (flush) begin
      main_vld_d = 1'b0;
      main_bus_d = '0;
      main_req_d = '0;
      skid_vld_d = 1'b0;
      skid_bus_d = '0;
      skid_req_d = '0;
    end else if (pop) begin
      if (accept) begin
        // accept implies the skid is empty, so the new entry goes straight to the head
        main_vld_d = 1'b1;
        main_bus_d = in_bus;
        main_req_d = in_req;
      end else if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_bus_d = skid_bus_q;
        main_req_d = skid_req_q;
        skid_vld_d = 1'b0;
        skid_bus_d = '0;
        skid_req_d = '0;
      end else begin
        // head drains into a bubble; zeroed fields keep a stale request from reissuing
        main_vld_d = 1'b0;
        main_bus_d = '0;
        main_req_d = '0;
      end
    end else if (accept) begin
      if (!main_vld_q) begin
        main_vld_d = 1'b1;
        main_bus_d = in_bus;
        main_req_d = in_req;
      end else begin
        skid_vld_d = 1'b1;
        skid_bus_d = in_bus;
        skid_req_d = in_req;
      end
    end
  end

  // State registers; reset clears entries immediately, independent of the clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_vld_q <= 1'b0;
      main_bus_q <= '0;
      main_req_q <= '0;
      skid_vld_q <= 1'b0;
      skid_bus_q <= '0;
      skid_req_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_bus_q <= main_bus_d;
      main_req_q <= main_req_d;
      skid_vld_q <= skid_vld_d;
      skid_bus_q <= skid_bus_d;
      skid_req_q <= skid_req_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: table vectors, hand-written corner sequences, random traffic against a queue model.
// Inputs change 3ns after a rising edge; outputs are sampled 1ns after the edge.
// The queue model holds at most two entries and pops in FIFO order.
module tb_pipe_stage_skid;

  localparam int DW = 64;
  localparam int RW = 69;
  localparam int SW = 6;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic [SW-1:0] stall;
  logic          in_valid;
  logic [DW-1:0] in_bus;
  logic [RW-1:0] in_req;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_bus;
  logic [RW-1:0] out_req;
  logic          out_ready;
  logic [1:0]    occ;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_WD(DW), .REQ_WD(RW), .STALL_WD(SW), .STAGE(ST), .ZERO_BUBBLE(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_bus(in_bus), .in_req(in_req), .in_ready(in_ready),
    .out_valid(out_valid), .out_bus(out_bus), .out_req(out_req), .out_ready(out_ready),
    .occ(occ)
  );

  // ---------------- reference model: a 2-deep FIFO queue ----------------
  typedef struct packed {
    logic [DW-1:0] bus;
    logic [RW-1:0] req;
  } ent_t;
  ent_t mq[$];

  task automatic model_edge();
    bit acc, pp;
    if (flush) begin
      mq.delete();
    end else begin
      pp  = (mq.size() > 0) && out_ready && !stall[ST+1];
      acc = in_valid && (mq.size() < 2) && !stall[ST];
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back('{bus: in_bus, req: in_req});
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(mq.size() > 0));
    chk({tag, ".occ"},       128'(occ),       128'(mq.size()));
    chk({tag, ".in_ready"},  128'(in_ready),  128'(mq.size() < 2));
    chk({tag, ".out_bus"},   128'(out_bus),   (mq.size() > 0) ? 128'(mq[0].bus) : 128'(0));
    chk({tag, ".out_req"},   128'(out_req),   (mq.size() > 0) ? 128'(mq[0].req) : 128'(0));
  endtask

  function automatic logic [RW-1:0] req_of(input logic [DW-1:0] b);
    return {1'b1, 4'hF, 32'h1000 + b[31:0], ~b[31:0]};
  endfunction

  task automatic drive(input bit fl, input logic [SW-1:0] st, input bit iv,
                       input logic [DW-1:0] b, input bit ordy);
    flush     = fl;
    stall     = st;
    in_valid  = iv;
    in_bus    = b;
    in_req    = req_of(b);
    out_ready = ordy;
  endtask

  // advance one edge, update the model, then settle before sampling
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit            fl;
    logic [SW-1:0] st;
    bit            iv;
    logic [DW-1:0] b;
    bit            ordy;
    bit            e_ov;
    logic [DW-1:0] e_bus;
    int            e_occ;
    bit            e_ir;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // back-pressure A,B,C; stall bubble; flush at occ=2 and occ=1
    tbl[0]  = '{0, 6'h00, 1, 64'h1, 0, 1, 64'h1, 1, 1};
    tbl[1]  = '{0, 6'h00, 1, 64'h2, 0, 1, 64'h1, 2, 0};
    tbl[2]  = '{0, 6'h00, 1, 64'h3, 0, 1, 64'h1, 2, 0};
    tbl[3]  = '{0, 6'h00, 1, 64'h3, 1, 1, 64'h2, 1, 1};
    tbl[4]  = '{0, 6'h00, 1, 64'h3, 1, 1, 64'h3, 1, 1};
    tbl[5]  = '{0, 6'h00, 0, 64'h0, 1, 0, 64'h0, 0, 1};
    tbl[6]  = '{0, 6'h00, 1, 64'h5, 0, 1, 64'h5, 1, 1};
    tbl[7]  = '{0, 6'h10, 1, 64'h9, 1, 0, 64'h0, 0, 1};
    tbl[8]  = '{0, 6'h00, 1, 64'h6, 0, 1, 64'h6, 1, 1};
    tbl[9]  = '{0, 6'h00, 1, 64'h7, 0, 1, 64'h6, 2, 0};
    tbl[10] = '{1, 6'h00, 1, 64'h8, 1, 0, 64'h0, 0, 1};
    tbl[11] = '{0, 6'h00, 1, 64'hA, 0, 1, 64'hA, 1, 1};
    tbl[12] = '{1, 6'h00, 1, 64'hB, 1, 0, 64'h0, 0, 1};

    resetn = 1'b0;
    drive(0, '0, 0, '0, 0);
    #2;
    chk("rst.out_valid", 128'(out_valid), 128'(0));
    chk("rst.in_ready",  128'(in_ready),  128'(1));
    chk("rst.occ",       128'(occ),       128'(0));
    chk("rst.out_bus",   128'(out_bus),   128'(0));
    chk("rst.out_req",   128'(out_req),   128'(0));
    @(posedge clk);
    #3 resetn = 1'b1;

    // table vectors
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].fl, tbl[i].st, tbl[i].iv, tbl[i].b, tbl[i].ordy);
      tick();
      chk($sformatf("tbl%0d.out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
      chk($sformatf("tbl%0d.out_bus", i),   128'(out_bus),   128'(tbl[i].e_bus));
      chk($sformatf("tbl%0d.out_req", i),   128'(out_req),
          tbl[i].e_ov ? 128'(req_of(tbl[i].e_bus)) : 128'(0));
      chk($sformatf("tbl%0d.occ", i),       128'(occ),       128'(tbl[i].e_occ));
      chk($sformatf("tbl%0d.in_ready", i),  128'(in_ready),  128'(tbl[i].e_ir));
      #2;
    end

    // asynchronous reset mid-cycle with the buffer full
    drive(0, '0, 1, 64'h21, 0); tick(); #2;
    drive(0, '0, 1, 64'h22, 0); tick();
    chk("arst.pre_occ", 128'(occ), 128'(2));
    #2 resetn = 1'b0;
    #1;
    mq.delete();
    chk("arst.out_valid", 128'(out_valid), 128'(0));
    chk("arst.occ",       128'(occ),       128'(0));
    chk("arst.out_req",   128'(out_req),   128'(0));
    chk("arst.in_ready",  128'(in_ready),  128'(1));
    drive(0, '0, 1, 64'h11, 0);
    resetn = 1'b1;
    tick();
    chk("arst.first_valid", 128'(out_valid), 128'(1));
    chk("arst.first_bus",   128'(out_bus),   128'(64'h11));
    #2;

    // downstream stall freezes the head request
    drive(1, '0, 0, '0, 0); tick(); #2;
    drive(0, '0, 1, 64'h44, 0);
    in_req = 69'h1F_0000_1000_DEAD_BEEF;
    tick(); #2;
    drive(0, 6'b110000, 1, 64'h55, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("dstall%0d.out_req", c), 128'(out_req), 128'(69'h1F_0000_1000_DEAD_BEEF));
      chk($sformatf("dstall%0d.occ", c),     128'(occ),     128'(1));
      #2;
    end

    // throughput: one beat per cycle with occupancy pinned at 1
    drive(1, '0, 0, '0, 0); tick(); #2;
    for (int k = 0; k < 16; k++) begin
      drive(0, '0, 1, 64'(k), 1);
      tick();
      chk($sformatf("thru%0d.out_bus", k), 128'(out_bus), 128'(k));
      chk($sformatf("thru%0d.occ", k),     128'(occ),     128'(1));
      #2;
    end
    drive(0, '0, 0, '0, 1); tick();
    chk("thru.drain_occ", 128'(occ), 128'(0));
    #2;

    // random traffic against the queue model
    for (int n = 0; n < 1500; n++) begin
      logic [SW-1:0] st;
      st       = SW'($urandom);
      st[ST]   = ($urandom_range(0, 3) == 0);
      st[ST+1] = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      stall     = st;
      in_valid  = $urandom_range(0, 1);
      in_bus    = {$urandom, $urandom};
      in_req    = {5'($urandom), $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      chk_model($sformatf("rnd%0d", n));
      #2;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
